// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
//
// Control and state-holding wrapper around an external AES-128 round datapath.
// It accepts one plaintext/key pair per handshake and performs the initial
// AddRoundKey itself. For each of the NR rounds it presents the state and the
// current round key to the datapath, then captures the round result and the
// next expanded key. The ciphertext is returned on an output handshake.
//
// Parameters:
//   NR         number of rounds (1..10, 10 for AES-128)
//   ROUND_LAT  cycles from operands presented to datapath results valid (>=1)
//
// Optional feature (compile-time macro AES_ABORT_EN):
//   Adds an 'abort' input. Asserting it in INIT, ROUND or DONE returns the
//   sequencer to IDLE on the next edge and clears all data registers.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   in_valid       plaintext/key pair valid
//   in_ready       high only in IDLE
//   plaintext_i    plaintext block
//   key_i          cipher key
//   out_valid      ciphertext valid, held until accepted
//   out_ready      consumer accepts ciphertext
//   abort          (AES_ABORT_EN only) discard the block in flight
//   ciphertext_o   state register, always visible; qualify with out_valid
//   busy           high in every state except IDLE
//   dp_state_o     state to datapath (srcA)
//   dp_key_o       current round key to datapath (srcB)
//   dp_round_o     current round 1..NR, 0 outside ROUND
//   dp_final_o     last round: datapath skips mixColumns
//   dp_rcon_o      round constant for key expansion, 0 outside ROUND
//   dp_result_i    round output after addRoundKey
//   dp_next_key_i  expanded key for the next round
// -----------------------------------------------------------------------------
module aes_round_sequencer #(
    parameter int NR        = 10,
    parameter int ROUND_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext_i,
    input  logic [127:0] key_i,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef AES_ABORT_EN
    input  logic         abort,
`endif
    output logic [127:0] ciphertext_o,
    output logic         busy,
    output logic [127:0] dp_state_o,
    output logic [127:0] dp_key_o,
    output logic [3:0]   dp_round_o,
    output logic         dp_final_o,
    output logic [7:0]   dp_rcon_o,
    input  logic [127:0] dp_result_i,
    input  logic [127:0] dp_next_key_i
);

    localparam int CNT_W = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;
    localparam logic [CNT_W-1:0] WAIT_RELOAD = CNT_W'(ROUND_LAT - 1);
    localparam logic [3:0]       LAST_ROUND  = 4'(NR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    fsm_t             fsm_r;
    fsm_t             fsm_s;
    logic [127:0]     data_r;
    logic [127:0]     data_s;
    logic [127:0]     key_r;
    logic [127:0]     key_s;
    logic [3:0]       round_r;
    logic [3:0]       round_s;
    logic [CNT_W-1:0] wait_r;
    logic [CNT_W-1:0] wait_s;
    logic             abort_hit_s;
    logic             in_round_s;

    // Key-expansion round constant for rounds 1..10.
    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

`ifdef AES_ABORT_EN
    // Abort only acts on a block in flight; IDLE ignores it.
    assign abort_hit_s = abort && (fsm_r != IDLE);
`else
    assign abort_hit_s = 1'b0;
`endif

    // Next-state and next-data computation for the sequencer.
    always_comb begin
        fsm_s   = fsm_r;
        data_s  = data_r;
        key_s   = key_r;
        round_s = round_r;
        wait_s  = wait_r;
        if (abort_hit_s) begin
            fsm_s   = IDLE;
            data_s  = 128'h0;
            key_s   = 128'h0;
            round_s = 4'd0;
            wait_s  = '0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    if (in_valid) begin
                        data_s = plaintext_i;
                        key_s  = key_i;
                        fsm_s  = INIT;
                    end else begin
                        fsm_s = IDLE;
                    end
                end
                INIT: begin
                    // Initial AddRoundKey with the cipher key.
                    data_s  = data_r ^ key_r;
                    round_s = 4'd1;
                    wait_s  = WAIT_RELOAD;
                    fsm_s   = ROUND;
                end
                ROUND: begin
                    if (wait_r != '0) begin
                        wait_s = wait_r - CNT_W'(1);
                    end else begin
                        data_s = dp_result_i;
                        key_s  = dp_next_key_i;
                        if (round_r == LAST_ROUND) begin
                            fsm_s = DONE;
                        end else begin
                            round_s = round_r + 4'd1;
                            wait_s  = WAIT_RELOAD;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_s   = IDLE;
                        round_s = 4'd0;
                    end else begin
                        fsm_s = DONE;
                    end
                end
                default: begin
                    fsm_s   = IDLE;
                    data_s  = 128'h0;
                    key_s   = 128'h0;
                    round_s = 4'd0;
                    wait_s  = '0;
                end
            endcase
        end
    end

    // State and data registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_r   <= IDLE;
            data_r  <= 128'h0;
            key_r   <= 128'h0;
            round_r <= 4'd0;
            wait_r  <= '0;
        end else begin
            fsm_r   <= fsm_s;
            data_r  <= data_s;
            key_r   <= key_s;
            round_r <= round_s;
            wait_r  <= wait_s;
        end
    end

    // All outputs decode directly from registered state, so they are glitch
    // free and take their reset values as soon as reset asserts.
    assign in_round_s   = (fsm_r == ROUND);
    assign in_ready     = (fsm_r == IDLE);
    assign busy         = (fsm_r != IDLE);
    assign out_valid    = (fsm_r == DONE);
    assign ciphertext_o = data_r;
    assign dp_state_o   = data_r;
    assign dp_key_o     = key_r;
    assign dp_round_o   = in_round_s ? round_r : 4'd0;
    assign dp_final_o   = in_round_s && (round_r == LAST_ROUND);
    assign dp_rcon_o    = in_round_s ? rcon_of(round_r) : 8'h00;

endmodule
